// File: rtl/uart_tx_stream_pkg.sv
// Shared constants for the buffered 8N1 UART transmitter: default baud divisors,
// baud-select encodings and the transmit FSM state type.
package uart_tx_stream_pkg;

    // src_clk cycles per bit at 50 MHz
    localparam int DIV_9600   = 5208;
    localparam int DIV_19200  = 2604;
    localparam int DIV_57600  = 868;
    localparam int DIV_115200 = 434;

    localparam logic [1:0] BAUD_SEL_9600   = 2'b00;
    localparam logic [1:0] BAUD_SEL_19200  = 2'b01;
    localparam logic [1:0] BAUD_SEL_57600  = 2'b10;
    localparam logic [1:0] BAUD_SEL_115200 = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_stream_sync_fifo.sv
// Synchronous FIFO with registered storage and first-word fall-through read data.
// A written word becomes readable one cycle after its write edge.
module uart_tx_stream_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      vis_ptr;
    logic             push;
    logic             pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    // The read side sees a lagged copy of the write pointer, so a fresh word
    // is only offered once it has settled in the memory.
    assign empty   = (vis_ptr == rd_ptr);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            vis_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            vis_ptr <= wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are sent LSB-first
// at a baud rate latched from baud_sel at the start of every frame.
module uart_tx_stream
    import uart_tx_stream_pkg::*;
#(
    parameter int DIV0       = DIV_9600,
    parameter int DIV1       = DIV_19200,
    parameter int DIV2       = DIV_57600,
    parameter int DIV3       = DIV_115200,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 13
) (
    input  logic                          src_clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [1:0]                    baud_sel,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);

    tx_state_t        state, state_nx;
    logic [CNT_W-1:0] baud_cnt, cnt_nx;
    logic [2:0]       bit_idx, idx_nx;
    logic [7:0]       shift_reg, shift_nx;
    logic [1:0]       sel_r, sel_nx;
    logic             pop;
    logic             empty;
    logic [7:0]       head;
    logic             start_ok;

    uart_tx_stream_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (src_clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    function automatic logic [CNT_W-1:0] div_m1(input logic [1:0] sel);
        case (sel)
            BAUD_SEL_9600:   return CNT_W'(DIV0 - 1);
            BAUD_SEL_19200:  return CNT_W'(DIV1 - 1);
            BAUD_SEL_57600:  return CNT_W'(DIV2 - 1);
            default:         return CNT_W'(DIV3 - 1);
        endcase
    endfunction

    assign start_ok = en && !empty;
    assign busy     = (state != TX_IDLE);

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            state     <= TX_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            sel_r     <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nx;
            baud_cnt  <= cnt_nx;
            bit_idx   <= idx_nx;
            shift_reg <= shift_nx;
            sel_r     <= sel_nx;
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = baud_cnt - CNT_W'(1);
        idx_nx   = bit_idx;
        shift_nx = shift_reg;
        sel_nx   = sel_r;
        pop      = 1'b0;
        tx       = 1'b1;
        case (state)
            TX_IDLE: begin
                cnt_nx = baud_cnt;
                if (start_ok) begin
                    pop      = 1'b1;
                    shift_nx = head;
                    sel_nx   = baud_sel;
                    cnt_nx   = div_m1(baud_sel);
                    state_nx = TX_START;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (baud_cnt == '0) begin
                    cnt_nx   = div_m1(sel_r);
                    idx_nx   = 3'd0;
                    state_nx = TX_DATA;
                end
            end
            TX_DATA: begin
                tx = shift_reg[0];
                if (baud_cnt == '0) begin
                    cnt_nx   = div_m1(sel_r);
                    shift_nx = {1'b0, shift_reg[7:1]};
                    idx_nx   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = TX_STOP;
                end
            end
            TX_STOP: begin
                if (baud_cnt == '0) begin
                    // Chain straight into the next frame so there is no idle gap.
                    if (start_ok) begin
                        pop      = 1'b1;
                        shift_nx = head;
                        sel_nx   = baud_sel;
                        cnt_nx   = div_m1(baud_sel);
                        state_nx = TX_START;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = TX_IDLE;
                    end
                end
            end
            default: state_nx = TX_IDLE;
        endcase
    end

endmodule
